if_ib_sender: RTL
=================

# if_ib_sender

Fetch-side producer for the instruction buffer's write port. It generates the fetch PC and issues one 16-byte line request at a time to the I$. It registers the returned four-word line together with the branch-prediction result, then presents it on the icache_ib_* bundle with icache_valid_ns until the buffer accepts it. It also steers fetch to a predicted target, including fetching a delay slot that spills into the next line, and restarts cleanly on flush/redirect.

## Interface
- RESET_PC, 32'hBFC0_0000: first fetch address after reset (word aligned).
- clk  in  1  clock; all state updates on posedge.
- rst_  in  1  asynchronous, active-low reset.
- flush  in  1  redirect; kills all in-flight work.
- flush_pc  in  32  redirect target (word aligned), used when flush=1.
- ic_req  out  1  line request valid.
- ic_addr  out  32  request PC; bits[1:0]=0, bits[3:2]=start word offset.
- ic_ready  in  1  I$ accepts request when ic_req&&ic_ready.
- ic_rvalid  in  1  response valid, one cycle, exactly one per accepted request.
- ic_rdata  in  128  line, word0 in [31:0] … word3 in [127:96].
- bp_hit  in  1  predicted-taken branch in this line (sampled with ic_rvalid).
- bp_slot  in  2  word index of the predicted branch.
- bp_target  in  32  predicted target.
- bp_ptab_idx  in  4  PTAB entry of the prediction.
- icache_ib_insn  out  128  line to IB.
- icache_ib_pc  out  32  fetch PC of the line (with offset).
- icache_ib_ptab_addr  out  5  {valid, idx}; bit 4 = prediction valid.
- icache_ib_delot_en  out  2  2'b00 normal line, 2'b10 delay-slot-only line; 2'b01 never driven.
- icache_ib_branch_pc  out  32  PC of predicted branch, 0 when none.
- icache_valid_ns  out  1  output bundle valid.
- ib_allin  in  1  IB can accept; transfer = icache_valid_ns && ib_allin.

## Operation
- State machine: REQ, RESP, HOLD. Registers: pc, tgt (saved target), dslot_pend, output bundle.
- REQ: ic_req=1, ic_addr=pc. On ic_ready, go to RESP.
- RESP: ic_req=0. On ic_rvalid, latch the line, pc and prediction into the output regs, set icache_valid_ns, and go to HOLD.
- Effective prediction: taken = bp_hit && (bp_slot >= pc[3:2]) && !dslot_pend. Not taken gives ptab_addr=5'b0 and branch_pc=0.
- Taken: ptab_addr={1'b1,bp_ptab_idx} and branch_pc={pc[31:4],bp_slot,2'b00}.
- Next pc is computed at latch and written on transfer:
  - dslot_pend: next pc = tgt; clear dslot_pend.
  - taken && bp_slot<3: next pc = bp_target.
  - taken && bp_slot==3: next pc = {pc[31:4]+1,4'b0}; set dslot_pend; tgt = bp_target.
  - otherwise: next pc = {pc[31:4]+1,4'b0}; 32-bit wrap allowed.
- Delay-slot line: fetched while dslot_pend=1, output with delot_en=2'b10, ptab_addr=0, branch_pc=0. Its pc offset is 00, so only word 0 is marked valid downstream.
- HOLD: all outputs stable while !ib_allin. On transfer, clear icache_valid_ns, apply next pc, and go to REQ.
- flush (highest priority, any state):
  - pc=flush_pc, dslot_pend=0, icache_valid_ns=0, delot_en=0, ptab_addr=0, then go to REQ next cycle.
  - If flushed in RESP, or in REQ with the request accepted that same cycle, set kill. The next ic_rvalid is discarded and clears kill. REQ is not issued while kill=1.
  - Flush in the same cycle as ic_rvalid or a transfer: flush wins, and the line is dropped (the transfer itself has occurred on the IB side).
- Reset: pc=RESET_PC, state=REQ, kill=0, dslot_pend=0. All outputs 0 except ic_req=1 and ic_addr=RESET_PC after the first edge; during reset ic_req=0.

## Timing
- One outstanding I$ request. Minimum line period is 3 cycles: REQ (1), RESP ≥1, HOLD ≥1.
- icache_valid_ns rises the cycle after ic_rvalid.
- ic_req falls the cycle after the ic_ready handshake.
- ic_addr is held constant while ic_req && !ic_ready.
- After flush, ic_req with flush_pc appears in the next cycle, unless kill is pending. In that case it appears the cycle after the killed ic_rvalid.
- No combinational path from ib_allin or ic_ready to any output.

## Test plan
- Sequential fetch: reset, ic_ready=1, 2-cycle I$, bp_hit=0, ib_allin=1 -> ic_addr BFC00000, BFC00010, BFC00020. Each line has ptab_addr=0 and delot_en=00.
- Backpressure: hold ib_allin=0 for 5 cycles with a line valid -> bundle bit-stable and no new ic_req. Release -> transfer in 1 cycle, then REQ at pc+16.
- Taken branch inside line: pc=00001004, bp_hit=1, slot=2, idx=7, target=00002000 -> ptab_addr=5'h17, branch_pc=00001008, next ic_addr=00002000.
- Spilled delay slot: pc=00001000, slot=3, target=00003000 -> next line 00001010 with delot_en=10 and ptab_addr=0, then ic_addr=00003000.
- Branch before offset: pc=0000100C, bp_hit=1, slot=1 -> treated as not taken, next ic_addr=00001010.
- Flush in RESP: flush_pc=80000000 -> stale ic_rvalid produces no icache_valid_ns. Next ic_addr=80000000, and no delot line follows even if dslot_pend was set.

Source files
------------

// File: rtl/if_ib_sender.sv
// if_ib_sender: fetch-side producer for the instruction buffer write port.
// Issues one I$ line request at a time and registers the returned line with its
// branch prediction. Holds the bundle until the IB accepts it, then steers fetch
// (sequential, predicted target, or spilled delay slot) and restarts on flush.
module if_ib_sender #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         flush,
  input  logic [31:0]  flush_pc,
  output logic         ic_req,
  output logic [31:0]  ic_addr,
  input  logic         ic_ready,
  input  logic         ic_rvalid,
  input  logic [127:0] ic_rdata,
  input  logic         bp_hit,
  input  logic [1:0]   bp_slot,
  input  logic [31:0]  bp_target,
  input  logic [3:0]   bp_ptab_idx,
  output logic [127:0] icache_ib_insn,
  output logic [31:0]  icache_ib_pc,
  output logic [4:0]   icache_ib_ptab_addr,
  output logic [1:0]   icache_ib_delot_en,
  output logic [31:0]  icache_ib_branch_pc,
  output logic         icache_valid_ns,
  input  logic         ib_allin
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned TAG_W  = XLEN - 4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   tgt;
  logic [XLEN-1:0]   next_pc;
  logic              dslot_pend;
  logic              kill;

  logic              taken_c;
  logic [XLEN-1:0]   seq_pc_c;
  logic [XLEN-1:0]   branch_pc_c;
  logic [XLEN-1:0]   next_pc_c;
  logic              kill_on_flush_c;

  // Prediction qualification and next-fetch selection for the line being latched.
  always_comb begin
    taken_c         = 1'b0;
    seq_pc_c        = '0;
    branch_pc_c     = '0;
    next_pc_c       = '0;
    kill_on_flush_c = 1'b0;

    taken_c     = bp_hit && (bp_slot >= pc[3:2]) && !dslot_pend;
    seq_pc_c    = {pc[XLEN-1:4] + TAG_W'(1), 4'b0000};
    branch_pc_c = {pc[XLEN-1:4], bp_slot, 2'b00};

    if (dslot_pend)                          next_pc_c = tgt;
    else if (taken_c && (bp_slot != 2'd3))   next_pc_c = bp_target;
    else                                     next_pc_c = seq_pc_c;

    // A flush leaves one I$ response outstanding that must be discarded.
    kill_on_flush_c = (kill && !ic_rvalid) ||
                      ((state == S_RESP) && !ic_rvalid) ||
                      ((state == S_REQ) && ic_req && ic_ready);
  end

  // Fetch FSM with registered request and IB bundle outputs.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state               <= S_REQ;
      pc                  <= RESET_PC;
      tgt                 <= '0;
      next_pc             <= '0;
      dslot_pend          <= 1'b0;
      kill                <= 1'b0;
      ic_req              <= 1'b0;
      ic_addr             <= '0;
      icache_ib_insn      <= '0;
      icache_ib_pc        <= '0;
      icache_ib_ptab_addr <= '0;
      icache_ib_delot_en  <= '0;
      icache_ib_branch_pc <= '0;
      icache_valid_ns     <= 1'b0;
    end else if (flush) begin
      state               <= S_REQ;
      pc                  <= flush_pc;
      dslot_pend          <= 1'b0;
      kill                <= kill_on_flush_c;
      ic_req              <= !kill_on_flush_c;
      ic_addr             <= {flush_pc[XLEN-1:2], 2'b00};
      icache_valid_ns     <= 1'b0;
      icache_ib_delot_en  <= 2'b00;
      icache_ib_ptab_addr <= 5'd0;
    end else begin
      case (state)
        S_REQ: begin
          if (kill) begin
            // Waiting for the stale response; restart request once it lands.
            if (ic_rvalid) begin
              kill    <= 1'b0;
              ic_req  <= 1'b1;
              ic_addr <= {pc[XLEN-1:2], 2'b00};
            end
          end else if (!ic_req) begin
            ic_req  <= 1'b1;
            ic_addr <= {pc[XLEN-1:2], 2'b00};
          end else if (ic_ready) begin
            ic_req <= 1'b0;
            state  <= S_RESP;
          end
        end
        S_RESP: begin
          if (ic_rvalid) begin
            icache_ib_insn      <= ic_rdata[LINE_W-1:0];
            icache_ib_pc        <= pc;
            icache_ib_ptab_addr <= taken_c ? {1'b1, bp_ptab_idx} : 5'd0;
            icache_ib_branch_pc <= taken_c ? branch_pc_c : '0;
            icache_ib_delot_en  <= dslot_pend ? 2'b10 : 2'b00;
            icache_valid_ns     <= 1'b1;
            next_pc             <= next_pc_c;
            if (dslot_pend) begin
              dslot_pend <= 1'b0;
            end else if (taken_c && (bp_slot == 2'd3)) begin
              dslot_pend <= 1'b1;
              tgt        <= bp_target;
            end
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (icache_valid_ns && ib_allin) begin
            icache_valid_ns <= 1'b0;
            pc              <= next_pc;
            ic_req          <= 1'b1;
            ic_addr         <= {next_pc[XLEN-1:2], 2'b00};
            state           <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule
